uart_inst_loader: RTL and testbench

UART_INST_LOADER -- requirements
Module: uart_inst_loader

---
 rtl/uart_inst_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_inst_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_inst_loader
//  Description : Assembles little-endian 32-bit instruction words from a UART
//                byte stream and writes them to consecutive instruction memory
//                addresses until a terminator word arrives or memory fills.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_inst_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              write_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  // Idle counter must be able to hold TIMEOUT_CYC itself.
  localparam int               c_IDLE_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT = c_IDLE_W'(TIMEOUT_CYC);
  // word_count value at which the memory is full.
  localparam logic [ADDR_W:0]  c_CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic [23:0]         r_buf, w_buf_nxt;        // bytes 0..2 of the word in progress
  logic [c_IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_addr_nxt;
  logic [31:0]         r_mem_wdata, w_wdata_nxt;
  logic [ADDR_W:0]     r_word_count, w_count_nxt;
  logic                r_write_done, w_done_nxt;
  logic                r_overflow, w_ovf_nxt;

  logic [31:0]         w_word;
  logic                w_expired;
  logic [1:0]          w_eff_idx;
  logic [ADDR_W:0]     w_count_inc;

  // State and datapath registers, cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= COLLECT;
      r_idx        <= 2'd0;
      r_buf        <= 24'd0;
      r_idle       <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_word_count <= '0;
      r_write_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_buf        <= w_buf_nxt;
      r_idle       <= w_idle_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_wdata  <= w_wdata_nxt;
      r_word_count <= w_count_nxt;
      r_write_done <= w_done_nxt;
      r_overflow   <= w_ovf_nxt;
    end
  end

  // Next-state, byte assembly, idle timeout and write bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_count_nxt = r_word_count;
    w_done_nxt  = r_write_done;
    w_ovf_nxt   = r_overflow;

    // Completed word if the incoming byte is the 4th one.
    w_word      = {uart_rx_data, r_buf};
    w_count_inc = r_word_count + 1'b1;
    // An expired partial word is dropped; a byte arriving in the same cycle
    // therefore lands as byte 0 of a fresh word.
    w_expired   = (r_idx != 2'd0) && (r_idle == c_TIMEOUT);
    w_eff_idx   = w_expired ? 2'd0 : r_idx;

    // Idle counter only runs while a partial word is pending.
    if ((r_state == DONE) || uart_rx_valid || (r_idx == 2'd0) || w_expired) begin
      w_idle_nxt = '0;
    end else begin
      w_idle_nxt = r_idle + 1'b1;
    end

    unique case (r_state)
      COLLECT: begin
        if (uart_rx_break) begin
          w_idx_nxt = 2'd0;
        end else if (uart_rx_valid) begin
          if (w_eff_idx == 2'd3) begin
            w_idx_nxt = 2'd0;
            if (w_word == END_WORD) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = WRITE;
              w_addr_nxt  = r_word_count[ADDR_W-1:0];
              w_wdata_nxt = w_word;
            end
          end else begin
            case (w_eff_idx)
              2'd0:    w_buf_nxt[7:0]   = uart_rx_data;
              2'd1:    w_buf_nxt[15:8]  = uart_rx_data;
              default: w_buf_nxt[23:16] = uart_rx_data;
            endcase
            w_idx_nxt = w_eff_idx + 2'd1;
          end
        end else if (w_expired) begin
          w_idx_nxt = 2'd0;
        end
      end

      WRITE: begin
        w_count_nxt = w_count_inc;
        w_idx_nxt   = 2'd0;
        if (w_count_inc == c_CAPACITY) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_ovf_nxt   = 1'b1;
        end else begin
          w_state_nxt = COLLECT;
          // A byte arriving during the write slot starts the next word.
          if (uart_rx_valid && !uart_rx_break) begin
            w_buf_nxt[7:0] = uart_rx_data;
            w_idx_nxt      = 2'd1;
          end
        end
      end

      DONE: begin
        w_idx_nxt = 2'd0;
      end

      default: begin
        w_state_nxt = COLLECT;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // Outputs: the write strobe is exactly the single WRITE cycle.
  always_comb begin
    mem_we     = (r_state == WRITE);
    mem_addr   = r_mem_addr;
    mem_wdata  = r_mem_wdata;
    write_done = r_write_done;
    overflow   = r_overflow;
    word_count = r_word_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_inst_loader
//  Description : Self-checking bench for uart_inst_loader. Two instances share
//                one byte stream (16-word and 4-word memories); a byte-stream
//                reference model predicts the writes and final flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_inst_loader;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic uart_rx_valid = 1'b0;
  logic uart_rx_break = 1'b0;
  logic [7:0] uart_rx_data = 8'd0;

  logic        we_a, done_a, ovf_a;
  logic [3:0]  addr_a;
  logic [31:0] wdata_a;
  logic [4:0]  wc_a;
  logic        we_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state, index 0 -> dut_a, 1 -> dut_b
  int          m_cap[2];
  bit          m_done[2];
  bit          m_ovf[2];
  int          m_count[2];
  int          m_last[2];
  logic [7:0]  m_part[2][$];
  logic [31:0] m_wr[2][$];
  logic [63:0] obs[2][$];

  uart_inst_loader #(.ADDR_W(4), .TIMEOUT_CYC(TMO)) dut_a (
    .clk(clk), .resetn(resetn),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .write_done(done_a), .overflow(ovf_a), .word_count(wc_a)
  );

  uart_inst_loader #(.ADDR_W(2), .TIMEOUT_CYC(TMO)) dut_b (
    .clk(clk), .resetn(resetn),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .write_done(done_b), .overflow(ovf_b), .word_count(wc_b)
  );

  always #5 clk = ~clk;

  // record every memory write seen on each instance
  always @(negedge clk) begin
    if (we_a) obs[0].push_back({32'(addr_a), wdata_a});
    if (we_b) obs[1].push_back({32'(addr_b), wdata_b});
  end

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // byte-stream model: words are 4 consecutive bytes, LSB first
  function automatic void model_ev(int k, bit v, bit brk, logic [7:0] d, int c);
    logic [31:0] w;
    if (m_done[k]) return;
    if (brk) begin
      m_part[k].delete();
      return;
    end
    if (!v) return;
    if (m_part[k].size() != 0 && (c - m_last[k] - 1) >= TMO) m_part[k].delete();
    m_part[k].push_back(d);
    m_last[k] = c;
    if (m_part[k].size() == 4) begin
      w = {m_part[k][3], m_part[k][2], m_part[k][1], m_part[k][0]};
      m_part[k].delete();
      if (w == 32'hFFFF_FFFF) begin
        m_done[k] = 1'b1;
      end else begin
        m_wr[k].push_back(w);
        m_count[k]++;
        if (m_count[k] == m_cap[k]) begin
          m_done[k] = 1'b1;
          m_ovf[k]  = 1'b1;
        end
      end
    end
  endfunction

  task automatic drive(bit v, bit brk, logic [7:0] d);
    uart_rx_valid = v;
    uart_rx_break = brk;
    uart_rx_data  = d;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_ev(k, v, brk, d, cyc);
    #1;
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_word(logic [31:0] w);
    drive(1'b1, 1'b0, w[7:0]);
    drive(1'b1, 1'b0, w[15:8]);
    drive(1'b1, 1'b0, w[23:16]);
    drive(1'b1, 1'b0, w[31:24]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("rst_we_a",    64'(we_a),    64'd0);
    chk("rst_addr_a",  64'(addr_a),  64'd0);
    chk("rst_wdata_a", 64'(wdata_a), 64'd0);
    chk("rst_done_a",  64'(done_a),  64'd0);
    chk("rst_ovf_a",   64'(ovf_a),   64'd0);
    chk("rst_wc_a",    64'(wc_a),    64'd0);
    chk("rst_done_b",  64'(done_b),  64'd0);
    chk("rst_ovf_b",   64'(ovf_b),   64'd0);
    chk("rst_wc_b",    64'(wc_b),    64'd0);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      m_ovf[k]  = 1'b0;
      m_count[k] = 0;
      m_last[k] = 0;
      m_part[k].delete();
      m_wr[k].delete();
      obs[k].delete();
    end
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(string tag);
    logic [5:0] wc;
    logic dn, ov;
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin wc = 6'(wc_a); dn = done_a; ov = ovf_a; end
      else        begin wc = 6'(wc_b); dn = done_b; ov = ovf_b; end
      chk($sformatf("%s_k%0d_nwrites", tag, k), 64'(obs[k].size()), 64'(m_wr[k].size()));
      n = (obs[k].size() < m_wr[k].size()) ? obs[k].size() : m_wr[k].size();
      for (int i = 0; i < n; i++)
        chk($sformatf("%s_k%0d_write%0d", tag, k, i), obs[k][i], {32'(i), m_wr[k][i]});
      chk($sformatf("%s_k%0d_count", tag, k), 64'(wc), 64'(m_count[k]));
      chk($sformatf("%s_k%0d_done", tag, k),  64'(dn), 64'(m_done[k]));
      chk($sformatf("%s_k%0d_ovf", tag, k),   64'(ov), 64'(m_ovf[k]));
    end
  endtask

  initial begin
    int g;
    m_cap[0] = 16;
    m_cap[1] = 4;

    // single word, back-to-back bytes
    do_reset();
    drive(1'b1, 1'b0, 8'h13);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b0, 8'hFD);
    idle(6);
    compare("one_word");
    chk("one_word_wdata_hold", 64'(wdata_a), 64'h0000_0000_FD01_0113);
    chk("one_word_addr_hold",  64'(addr_a),  64'd0);
    chk("one_word_we_low",     64'(we_a),    64'd0);
    chk("one_word_count",      64'(wc_a),    64'd1);

    // terminator stops the load, second terminator harmless
    do_reset();
    send_word(32'h0000_0000);
    send_word(32'h0000_0000);
    send_word(32'hFD01_0113);
    send_word(32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    idle(3);
    compare("terminator");
    chk("terminator_count", 64'(wc_a),   64'd3);
    chk("terminator_done",  64'(done_a), 64'd1);

    // break discards a partial word
    do_reset();
    drive(1'b1, 1'b0, 8'h23);
    drive(1'b1, 1'b0, 8'h26);
    drive(1'b0, 1'b1, 8'h00);
    send_word(32'h0301_0413);
    idle(3);
    compare("break");
    chk("break_wdata", 64'(wdata_a), 64'h0000_0000_0301_0413);

    // break coinciding with a byte drops that byte
    do_reset();
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b1, 8'h22);
    send_word(32'hA5A5_5A5A);
    idle(3);
    compare("break_valid");

    // idle timeout discards a partial word
    do_reset();
    drive(1'b1, 1'b0, 8'hAA);
    idle(20);
    send_word(32'h0010_0793);
    idle(3);
    compare("timeout");
    chk("timeout_wdata", 64'(wdata_a), 64'h0000_0000_0010_0793);

    // gaps just below and exactly at the timeout
    do_reset();
    drive(1'b1, 1'b0, 8'h01);
    idle(TMO - 1);
    drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b0, 8'h04);
    drive(1'b1, 1'b0, 8'h05);
    idle(TMO);
    drive(1'b1, 1'b0, 8'h06);
    drive(1'b1, 1'b0, 8'h07);
    drive(1'b1, 1'b0, 8'h08);
    drive(1'b1, 1'b0, 8'h09);
    idle(3);
    compare("timeout_edge");

    // memory full on the 4-word instance
    do_reset();
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h4444_4444);
    idle(3);
    send_word(32'h5555_5555);
    idle(3);
    compare("overflow");
    chk("overflow_flag_b", 64'(ovf_b),  64'd1);
    chk("overflow_done_b", 64'(done_b), 64'd1);
    chk("overflow_wc_b",   64'(wc_b),   64'd4);

    // reset in the middle of a word
    do_reset();
    send_word(32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 8'h77);
    drive(1'b1, 1'b0, 8'h66);
    do_reset();
    send_word(32'h1234_5678);
    idle(3);
    compare("mid_reset");

    // randomized byte streams with breaks and long gaps
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int e = 0; e < 60; e++) begin
        if ($urandom_range(0, 9) == 0) g = $urandom_range(TMO - 2, TMO + 2);
        else g = $urandom_range(0, 2);
        idle(g);
        if ($urandom_range(0, 19) == 0)
          drive(bit'($urandom_range(0, 1)), 1'b1, 8'($urandom));
        else if ($urandom_range(0, 2) == 0)
          drive(1'b1, 1'b0, 8'hFF);
        else
          drive(1'b1, 1'b0, 8'($urandom));
      end
      idle(3);
      compare($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
